fetch_unit: RTL and testbench

Instruction-fetch stage that drives the IF/ID pipeline register: owns the program counter, runs a variable-latency request/acknowledge handshake with the instruction memory/cache, and presents `pc_o`/`inst_o` for IF/ID to capture. It honours the pipeline-control inputs (PC write enable from hazard detection, global halt from the memory system, branch redirect) and generates the IF/ID flush and an instruction-fetch stall toward the pipeline halt network.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/fetch_perf_cnt.sv | 43 ++++
 rtl/fetch_unit.sv | 146 ++++++++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: fetch FSM encodings, default NOP word, PC increment.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pipe_pkg;

  // Fetch FSM encodings, kept as plain constants for legacy tool flows.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Fetch performance counter pair: advances and fetch-stall cycles, 32-bit wrapping.
// Latency: counts are visible the cycle after the event.
// Backpressure: none; counting pauses while en_i is low (pipeline halt).
module fetch_perf_cnt
  import pipe_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        fetch_inc_i,
  input  logic        stall_inc_i,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
);

  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Next-count logic: increment on events, hold while disabled.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (en_i) begin
      if (fetch_inc_i) fetch_cnt_d = fetch_cnt_q + 32'd1;
      if (stall_inc_i) stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Counter registers with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, handshakes with imem, presents pc/inst to IF/ID.
// Latency: zero-wait ack gives one instruction per cycle; an N-cycle miss stalls N cycles.
// Backpressure: pc_write_i=0 or halt_i=1 holds the PC; an early ack is parked in a hold buffer.
// Optional: FETCH_PERF_EN adds advance/stall performance counters.
module fetch_unit
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pc_write_i,
  input  logic        halt_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        flush_o,
  output logic        ifetch_stall_o,
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_stall_o
);

  logic [31:0] pc_q, pc_d;
  logic [1:0]  state_q, state_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic        hold_valid_q, hold_valid_d;
  // Address of the abandoned request; must stay on the bus until its ack.
  logic [31:0] drop_addr_q, drop_addr_d;

  logic redirect;
  logic avail;
  logic advance;

  assign redirect = branch_i & ~halt_i;

  // Output decode and next-state logic for PC, FSM and hold buffer.
  always_comb begin
    pc_d           = pc_q;
    state_d        = state_q;
    hold_inst_d    = hold_inst_q;
    hold_valid_d   = hold_valid_q;
    drop_addr_d    = drop_addr_q;
    imem_req_o     = 1'b0;
    imem_addr_o    = pc_q;
    pc_o           = 32'h0;
    inst_o         = NOP_INST;
    flush_o        = 1'b0;
    ifetch_stall_o = 1'b0;
    avail          = 1'b0;
    advance        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        if (redirect) begin
          flush_o = 1'b1;
          pc_d    = branch_target_i;
        end
      end

      ST_REQ: begin
        // A parked word means the fetch at pc_q is already complete.
        imem_req_o = ~hold_valid_q;
        avail      = hold_valid_q | (imem_req_o & imem_ack_i);
        if (avail) begin
          inst_o = hold_valid_q ? hold_inst_q : imem_data_i;
          pc_o   = pc_q + PC_INC;
        end else begin
          ifetch_stall_o = 1'b1;
        end

        if (redirect) begin
          flush_o      = 1'b1;
          pc_d         = branch_target_i;
          hold_valid_d = 1'b0;
          // An in-flight request must be drained before fetching the target.
          if (imem_req_o && !imem_ack_i) begin
            state_d     = ST_DROP;
            drop_addr_d = pc_q;
          end
        end else if (avail && pc_write_i && !halt_i) begin
          advance      = 1'b1;
          pc_d         = pc_q + PC_INC;
          hold_valid_d = 1'b0;
        end else if (imem_req_o && imem_ack_i) begin
          hold_inst_d  = imem_data_i;
          hold_valid_d = 1'b1;
        end
      end

      ST_DROP: begin
        imem_req_o     = 1'b1;
        imem_addr_o    = drop_addr_q;
        ifetch_stall_o = 1'b1;
        if (redirect) begin
          flush_o = 1'b1;
          pc_d    = branch_target_i;
        end
        // The stale transaction completes even under halt; re-requesting it
        // would be pointless, so leave DROP as soon as it is acknowledged.
        if (imem_ack_i) state_d = ST_REQ;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Fetch state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q         <= RESET_PC;
      state_q      <= ST_IDLE;
      hold_inst_q  <= '0;
      hold_valid_q <= 1'b0;
      drop_addr_q  <= '0;
    end else begin
      pc_q         <= pc_d;
      state_q      <= state_d;
      hold_inst_q  <= hold_inst_d;
      hold_valid_q <= hold_valid_d;
      drop_addr_q  <= drop_addr_d;
    end
  end

`ifdef FETCH_PERF_EN
  fetch_perf_cnt u_perf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (~halt_i),
    .fetch_inc_i (advance),
    .stall_inc_i (ifetch_stall_o),
    .fetch_cnt_o (perf_fetch_o),
    .stall_cnt_o (perf_stall_o)
  );
`else
  assign perf_fetch_o = 32'h0;
  assign perf_stall_o = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a scoreboard of expected pc/inst pairs.
// Latency: expectations are pushed in the cycle an instruction should appear.
// Backpressure: pc_write_i/halt_i are driven by the directed steps.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        pc_write_i;
  logic        halt_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        flush_o;
  logic        ifetch_stall_o;
  logic [31:0] perf_fetch_o;
  logic [31:0] perf_stall_o;

  int   checks  = 0;
  int   errors  = 0;
  int   adv_cnt = 0;
  logic in_run  = 1'b0;
  exp_t sb[$];

  fetch_unit #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .pc_write_i      (pc_write_i),
    .halt_i          (halt_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ack_i      (imem_ack_i),
    .imem_data_i     (imem_data_i),
    .pc_o            (pc_o),
    .inst_o          (inst_o),
    .flush_o         (flush_o),
    .ifetch_stall_o  (ifetch_stall_o),
    .perf_fetch_o    (perf_fetch_o),
    .perf_stall_o    (perf_stall_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'hCAFE_0000;
  endfunction

  // Memory content is a fixed function of the address on the bus.
  assign imem_data_i = memw(imem_addr_o);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic br, input logic [31:0] tgt, input logic ack,
                       input logic pw, input logic hlt);
    branch_i        = br;
    branch_target_i = tgt;
    imem_ack_i      = ack;
    pc_write_i      = pw;
    halt_i          = hlt;
    #1;
  endtask

  // Pop and compare when IF/ID would capture an instruction this cycle.
  task automatic consume();
    exp_t e;
    if (in_run && !ifetch_stall_o && pc_write_i && !halt_i && !branch_i) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("pc_o", pc_o, e.pc);
        chk("inst_o", inst_o, e.inst);
        adv_cnt++;
      end
    end
  endtask

  task automatic nxt();
    consume();
    @(posedge clk_i);
    #1;
  endtask

  task automatic fetch_ok(input logic [31:0] a);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("hit_req", {31'h0, imem_req_o}, 32'd1);
    chk("hit_addr", imem_addr_o, a);
    chk("hit_stall", {31'h0, ifetch_stall_o}, 32'd0);
    sb.push_back('{pc: a + 32'd4, inst: memw(a)});
    nxt();
  endtask

  initial begin
    rst_i = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    @(posedge clk_i); @(posedge clk_i); #1;

    // Reset state.
    chk("rst_req", {31'h0, imem_req_o}, 32'd0);
    chk("rst_pc_o", pc_o, 32'h0);
    chk("rst_inst", inst_o, NOP);
    chk("rst_flush", {31'h0, flush_o}, 32'd0);
    chk("rst_stall", {31'h0, ifetch_stall_o}, 32'd0);
    chk("rst_perf_f", perf_fetch_o, 32'h0);
    chk("rst_perf_s", perf_stall_o, 32'h0);

    // First cycle out of reset is IDLE: no request yet.
    rst_i = 1'b0;
    #1;
    chk("idle_req", {31'h0, imem_req_o}, 32'd0);
    nxt();
    in_run = 1'b1;

    // Back-to-back zero-wait hits.
    fetch_ok(32'h100);
    fetch_ok(32'h104);
    fetch_ok(32'h108);

    // Three-cycle miss at 0x10C.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      chk("miss_stall", {31'h0, ifetch_stall_o}, 32'd1);
      chk("miss_inst", inst_o, NOP);
      chk("miss_pc_o", pc_o, 32'h0);
      chk("miss_addr", imem_addr_o, 32'h10C);
      nxt();
    end
    fetch_ok(32'h10C);

    // Ack while pc_write is low: word parked, request dropped, then advance.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("hold_cap_req", {31'h0, imem_req_o}, 32'd1);
    chk("hold_cap_pc", pc_o, 32'h114);
    sb.push_back('{pc: 32'h114, inst: memw(32'h110)});
    nxt();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("hold_req", {31'h0, imem_req_o}, 32'd0);
    chk("hold_pc", pc_o, 32'h114);
    chk("hold_inst", inst_o, memw(32'h110));
    nxt();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("hold_rel_req", {31'h0, imem_req_o}, 32'd0);
    chk("hold_rel_stall", {31'h0, ifetch_stall_o}, 32'd0);
    nxt();

    // Redirect during an unacknowledged miss at 0x114.
    drive(1'b1, 32'h200, 1'b0, 1'b1, 1'b0);
    chk("br_flush", {31'h0, flush_o}, 32'd1);
    chk("br_stall", {31'h0, ifetch_stall_o}, 32'd1);
    nxt();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("drop_req", {31'h0, imem_req_o}, 32'd1);
    chk("drop_addr", imem_addr_o, 32'h114);
    chk("drop_flush", {31'h0, flush_o}, 32'd0);
    nxt();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("drop_ack_stall", {31'h0, ifetch_stall_o}, 32'd1);
    chk("drop_ack_inst", inst_o, NOP);
    nxt();
    fetch_ok(32'h200);

    // Halt with a pending redirect: nothing moves until halt falls.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h300, 1'b0, 1'b1, 1'b1);
      chk("halt_flush", {31'h0, flush_o}, 32'd0);
      chk("halt_addr", imem_addr_o, 32'h204);
      nxt();
    end
    drive(1'b1, 32'h300, 1'b1, 1'b1, 1'b0);
    chk("halt_fall_flush", {31'h0, flush_o}, 32'd1);
    nxt();

    // Redirect coinciding with an ack, then PC wrap.
    drive(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
    chk("br_ack_addr", imem_addr_o, 32'h300);
    chk("br_ack_flush", {31'h0, flush_o}, 32'd1);
    nxt();
    fetch_ok(32'hFFFF_FFFC);
    fetch_ok(32'h0000_0000);

    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("sb_empty", sb.size(), 32'd0);
`ifdef FETCH_PERF_EN
    chk("perf_fetch", perf_fetch_o, adv_cnt);
`else
    chk("perf_fetch_off", perf_fetch_o, 32'h0);
    chk("perf_stall_off", perf_stall_o, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
